// File: rtl/mul32_seq_if.sv
// Handshake/operand bundle for the sequential multiplier.
// master drives op_start/op_clear/operands; slave returns busy/done/result.
interface mul32_seq_if;
  logic        op_start;
  logic        op_clear;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        op_busy;
  logic        op_done;
  logic [63:0] result;

  modport master (
    output op_start, op_clear, multiplicand, multiplier,
    input  op_busy, op_done, result
  );

  modport slave (
    input  op_start, op_clear, multiplicand, multiplier,
    output op_busy, op_done, result
  );
endinterface

// File: rtl/mul32_seq.sv
// Radix-2 sequential 32x32 multiplier (IDLE/EXEC/DONE), 32 EXEC cycles.
// Ports: clk, reset_n (async low), bus (mul32_seq_if.slave).
// Define MUL32_SIGNED_EN for Booth signed mode; default is unsigned.

module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] sum,
  output logic        co
);
  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [8:0]  gc;

  assign g = a & b;
  assign p = a ^ b;
  assign gc[0] = ci;

  for (genvar k = 0; k < 8; k++) begin : grp
    localparam int B = 4 * k;
    assign c[B]   = gc[k];
    assign c[B+1] = g[B]
                  | (p[B] & gc[k]);
    assign c[B+2] = g[B+1]
                  | (p[B+1] & g[B])
                  | (p[B+1] & p[B] & gc[k]);
    assign c[B+3] = g[B+2]
                  | (p[B+2] & g[B+1])
                  | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & gc[k]);
    assign gg[k]  = g[B+3]
                  | (p[B+3] & g[B+2])
                  | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign gp[k]  = &p[B+3:B];
    assign gc[k+1] = gg[k] | (gp[k] & gc[k]);
  end

  assign sum = p ^ c;
  assign co  = gc[8];
endmodule

module mul32_seq (
  input logic       clk,
  input logic       reset_n,
  mul32_seq_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] acc;
  logic [31:0] q;
  logic [31:0] mcand;
  logic [4:0]  count;
  logic        busy;
  logic        done;

  logic [31:0] opnd;
  logic        ci;
  logic [31:0] sum;
  logic        co;
  logic        ext;

`ifdef MUL32_SIGNED_EN
  logic q_m1;

  always_comb begin
    opnd = '0;
    ci   = 1'b0;
    unique case ({q[0], q_m1})
      2'b01: opnd = mcand;
      2'b10: begin
        opnd = ~mcand;
        ci   = 1'b1;
      end
      default: ;
    endcase
  end

  // True sign of the 33-bit sum, so a -2^31 operand cannot overflow.
  assign ext = acc[31] ^ opnd[31] ^ co;
`else
  assign opnd = q[0] ? mcand : '0;
  assign ci   = 1'b0;
  assign ext  = co;
`endif

  cla32 u_cla (
    .a  (acc),
    .b  (opnd),
    .ci (ci),
    .sum(sum),
    .co (co)
  );

  assign bus.op_busy = busy;
  assign bus.op_done = done;
  assign bus.result  = {acc, q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      acc   <= '0;
      q     <= '0;
      mcand <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef MUL32_SIGNED_EN
      q_m1  <= 1'b0;
`endif
    end else if (bus.op_clear) begin
      state <= IDLE;
      acc   <= '0;
      q     <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef MUL32_SIGNED_EN
      q_m1  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.op_start) begin
            state <= EXEC;
            acc   <= '0;
            q     <= bus.multiplier;
            mcand <= bus.multiplicand;
            count <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
`ifdef MUL32_SIGNED_EN
            q_m1  <= 1'b0;
`endif
          end
        end
        EXEC: begin
          acc   <= {ext, sum[31:1]};
          q     <= {sum[0], q[31:1]};
          count <= count + 5'd1;
`ifdef MUL32_SIGNED_EN
          q_m1  <= q[0];
`endif
          if (count == 5'd31) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
